dmi_jtag_dr_ctrl: RTL

// DMIACCESS data-register stage of the debug transport module. It sits directly downstream of the

---
 rtl/dmi_jtag_dr_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmi_jtag_dr_ctrl.sv
// DMIACCESS data-register stage of the debug transport module.
// Takes the TAP capture/shift/update strobes for the DMIACCESS register and
// builds {addr, data, op} DMI requests from them. It issues each request to the
// debug module over valid/ready and collects the response. It also keeps the
// sticky dmistat error that the TAP reports in DTMCS.
//
// Ports
//   tck_i, rst_i         : test clock, synchronous active-high reset
//   test_logic_reset_i   : TAP is in Test-Logic-Reset (clears dr_q and error)
//   capture_dr_i / shift_dr_i / update_dr_i : TAP DR strobes
//   dmi_access_i         : the IR selects DMIACCESS; it gates all three strobes
//   dmi_reset_i          : dtmcs.dmireset, clears the sticky error
//   dmi_tdi_i / dmi_tdo_o: serial in / serial out (dmi_tdo_o = dr_q[0])
//   dmi_error_o          : sticky error (0 none, 2 op failed, 3 busy)
//   dmi_req_*            : request channel to the debug module
//   dmi_resp_*           : response channel from the debug module
module dmi_jtag_dr_ctrl #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 tck_i,
  input  logic                 rst_i,
  input  logic                 test_logic_reset_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_access_i,
  input  logic                 dmi_reset_i,
  input  logic                 dmi_tdi_i,
  output logic                 dmi_tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DataWidth = 32;
  localparam int unsigned OpWidth   = 2;
  localparam int unsigned DrWidth   = AddrWidth + DataWidth + OpWidth;

  localparam logic [1:0] OpRead     = 2'd1;
  localparam logic [1:0] OpWrite    = 2'd2;
  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrFailed  = 2'd2;
  localparam logic [1:0] ErrBusy    = 2'd3;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } state_e;

  state_e                 state_q;
  logic [DrWidth-1:0]     dr_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   data_q;
  logic [1:0]             error_q;
  logic                   req_valid_q;
  logic                   resp_ready_q;
  logic [1:0]             req_op_q;

  logic                   acc_capture;
  logic                   acc_shift;
  logic                   acc_update;
  logic                   in_idle;
  logic                   resp_fire;
  logic                   busy_hit;
  logic [1:0]             cap_err;
  logic [1:0]             error_d;

  // Strobes only count while the IR selects DMIACCESS
  assign acc_capture = dmi_access_i & capture_dr_i;
  assign acc_shift   = dmi_access_i & shift_dr_i;
  assign acc_update  = dmi_access_i & update_dr_i;
  assign in_idle     = (state_q == Idle);
  assign resp_fire   = ((state_q == WaitRead) || (state_q == WaitWrite)) & dmi_resp_valid_i;
  // A capture or update that arrives while a transaction is in flight counts as busy
  assign busy_hit    = (acc_capture | acc_update) & ~in_idle;

  // The captured op field already shows busy if this capture is the one that raises it
  assign cap_err = ((error_q == ErrNone) && !in_idle) ? ErrBusy : error_q;

  // Sticky error update. The two clears override any error raised in the same cycle.
  always_comb begin
    error_d = error_q;
    if (error_q == ErrNone) begin
      if (busy_hit) begin
        error_d = ErrBusy;
      end else if (resp_fire && (dmi_resp_resp_i != 2'd0)) begin
        error_d = ErrFailed;
      end
    end
    if (test_logic_reset_i) begin
      error_d = ErrNone;
    end
    if (dmi_reset_i) begin
      error_d = ErrNone;
    end
  end

  // Shift register, request fields and the transaction FSM
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      dr_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      error_q      <= ErrNone;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      req_op_q     <= 2'd0;
    end else begin
      error_q <= error_d;

      if (test_logic_reset_i) begin
        dr_q <= '0;
      end else if (acc_capture) begin
        dr_q <= {addr_q, data_q, cap_err};
      end else if (acc_shift) begin
        dr_q <= {dmi_tdi_i, dr_q[DrWidth-1:1]};
      end

      case (state_q)
        Idle: begin
          // An update is dropped while an error is pending
          if (acc_update && (error_q == ErrNone)) begin
            addr_q <= dr_q[DrWidth-1 -: AddrWidth];
            if (dr_q[OpWidth-1:0] == OpRead) begin
              state_q     <= Read;
              req_valid_q <= 1'b1;
              req_op_q    <= OpRead;
            end else if (dr_q[OpWidth-1:0] == OpWrite) begin
              state_q     <= Write;
              req_valid_q <= 1'b1;
              req_op_q    <= OpWrite;
              data_q      <= dr_q[OpWidth +: DataWidth];
            end
          end
        end
        Read, Write: begin
          if (dmi_req_ready_i) begin
            state_q      <= (state_q == Read) ? WaitRead : WaitWrite;
            req_valid_q  <= 1'b0;
            req_op_q     <= 2'd0;
            resp_ready_q <= 1'b1;
          end
        end
        WaitRead, WaitWrite: begin
          if (dmi_resp_valid_i) begin
            if (state_q == WaitRead) begin
              data_q <= dmi_resp_data_i;
            end
            state_q      <= Idle;
            resp_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= Idle;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          req_op_q     <= 2'd0;
        end
      endcase
    end
  end

  assign dmi_tdo_o        = dr_q[0];
  assign dmi_error_o      = error_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_req_op_o     = req_op_q;
  assign dmi_resp_ready_o = resp_ready_q;

endmodule
